// File: rtl/fb_scanout_ctrl.sv
// Frame-buffer scanout controller: fetches a 32bpp frame with Avalon-MM
// burst reads into a show-ahead pixel FIFO and streams it out as one
// Avalon-ST packet per frame. Read requests are paced by FIFO credit so
// the FIFO never overflows and the slave is never back-pressured.
//
// Handshakes: a memory burst is accepted on any rising edge where
// avm_read=1 and avm_waitrequest=0; a pixel is transferred on any rising
// edge where src_valid=1 and src_ready=1. avm_read/avm_address and
// src_valid/src_data never depend combinationally on the other side.
module fb_scanout_ctrl #(
    parameter int unsigned H_ACTIVE   = 1024,
    parameter int unsigned V_ACTIVE   = 768,
    parameter int unsigned BURST      = 16,
    parameter int unsigned FIFO_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cfg_base,
    input  logic        cfg_enable,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic [6:0]  avm_burstcount,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic [23:0] src_data,
    output logic        src_valid,
    input  logic        src_ready,
    output logic        src_sop,
    output logic        src_eop,
    output logic        busy,
    output logic        frame_done,
    output logic [1:0]  dbg_state
);
    localparam int unsigned TOTAL   = H_ACTIVE * V_ACTIVE;
    localparam int unsigned NBURSTS = TOTAL / BURST;
    localparam int unsigned PIX_W   = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int unsigned REQ_W   = $clog2(NBURSTS + 1);
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned SHIFT   = $clog2(BURST) + 2;

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(TOTAL - 1);
    localparam logic [PIX_W-1:0] PIX_ONE  = PIX_W'(1);
    localparam logic [REQ_W-1:0] REQ_DONE = REQ_W'(NBURSTS);
    localparam logic [REQ_W-1:0] REQ_ONE  = REQ_W'(1);
    localparam logic [CNT_W-1:0] BURST_C  = CNT_W'(BURST);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ISSUE       = 2'd1,
        WAIT_CREDIT = 2'd2,
        DRAIN       = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        frame_addr_q, frame_addr_d;
    logic [REQ_W-1:0]   req_cnt_q, req_cnt_d;
    logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               frame_done_q, frame_done_d;
    logic [23:0]        mem_q [FIFO_DEPTH];

    logic               push, pop, accept, last_pop, credit_ok;
    logic [CNT_W-1:0]   credit;
    logic [REQ_W-1:0]   req_inc;
    logic               unused_bits;

    // Alpha byte and the sub-word address bits carry no information here.
    assign unused_bits = ^{avm_readdata[31:24], cfg_base[1:0]};

    // Beats are only pushed while requested; stale beats after reset are dropped.
    assign push      = avm_readdatavalid && (outstanding_q != '0);
    assign pop       = src_valid && src_ready;
    assign accept    = (state_q == ISSUE) && !avm_waitrequest;
    assign last_pop  = pop && (pix_cnt_q == PIX_LAST);
    // fifo_cnt + outstanding never exceeds FIFO_DEPTH, so this cannot underflow.
    assign credit    = DEPTH_C - fifo_cnt_q - outstanding_q;
    assign credit_ok = (credit >= BURST_C);
    assign req_inc   = req_cnt_q + REQ_ONE;

    // Request side: state, frame base and burst/pixel counters.
    always_comb begin
        state_d      = state_q;
        frame_addr_d = frame_addr_q;
        req_cnt_d    = req_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        if (pop) begin
            pix_cnt_d = last_pop ? '0 : pix_cnt_q + PIX_ONE;
        end
        case (state_q)
            IDLE: begin
                if (cfg_enable) begin
                    frame_addr_d = {cfg_base[31:2], 2'b00};
                    req_cnt_d    = '0;
                    pix_cnt_d    = '0;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (accept) begin
                    req_cnt_d = req_inc;
                    state_d   = (req_inc == REQ_DONE) ? DRAIN : WAIT_CREDIT;
                end
            end
            WAIT_CREDIT: begin
                if (credit_ok) begin
                    state_d = ISSUE;
                end
            end
            DRAIN: begin
                // The frame boundary is the frame_done cycle; enable is sampled here.
                if (frame_done_q) begin
                    if (cfg_enable) begin
                        frame_addr_d = {cfg_base[31:2], 2'b00};
                        req_cnt_d    = '0;
                        pix_cnt_d    = '0;
                        state_d      = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Data side: in-flight beat count, FIFO occupancy and pointers.
    always_comb begin
        outstanding_d = outstanding_q;
        fifo_cnt_d    = fifo_cnt_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        frame_done_d  = last_pop;
        if (accept) begin
            outstanding_d = outstanding_d + BURST_C;
        end
        if (push) begin
            outstanding_d = outstanding_d - CNT_ONE;
            fifo_cnt_d    = fifo_cnt_d + CNT_ONE;
            wr_ptr_d      = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            fifo_cnt_d = fifo_cnt_d - CNT_ONE;
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
        end
    end

    // State and counter registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            frame_addr_q  <= '0;
            req_cnt_q     <= '0;
            pix_cnt_q     <= '0;
            outstanding_q <= '0;
            fifo_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_addr_q  <= frame_addr_d;
            req_cnt_q     <= req_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
            outstanding_q <= outstanding_d;
            fifo_cnt_q    <= fifo_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            frame_done_q  <= frame_done_d;
        end
    end

    // Pixel storage; contents are only meaningful while fifo_cnt is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= avm_readdata[23:0];
        end
    end

    assign avm_read       = (state_q == ISSUE);
    assign avm_address    = avm_read ? (frame_addr_q + (32'(req_cnt_q) << SHIFT)) : '0;
    assign avm_burstcount = 7'(BURST);
    assign src_valid      = (fifo_cnt_q != '0);
    assign src_data       = mem_q[rd_ptr_q];
    assign src_sop        = src_valid && (pix_cnt_q == '0);
    assign src_eop        = src_valid && (pix_cnt_q == PIX_LAST);
    assign busy           = (state_q != IDLE);
    assign frame_done     = frame_done_q;
    assign dbg_state      = state_q;

endmodule
